// File: rtl/umi_arb_pkg.sv
// Shared helpers for the UMI request round-robin arbiter: index-width sizing
// and the reference round-robin pick used by the arbitration sub-module.
package umi_arb_pkg;

    localparam int unsigned MAXN = 32;

    // Width needed to index v entries, never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

    // One-hot grant of the first valid port at or after ptr, modulo n.
    function automatic logic [MAXN-1:0] rr_pick(
        input logic [MAXN-1:0] valid,
        input int unsigned     n,
        input int unsigned     ptr
    );
        logic [2*MAXN-1:0] dbl;
        logic [MAXN-1:0]   rot;
        logic [MAXN-1:0]   grot;
        logic [MAXN-1:0]   g;
        logic              found;
        int unsigned       p;

        p     = ptr % n;
        dbl   = '0;
        rot   = '0;
        grot  = '0;
        g     = '0;
        found = 1'b0;

        for (int unsigned i = 0; i < MAXN; i++) begin
            if (i < n) begin
                dbl[i]     = valid[i];
                dbl[i + n] = valid[i];
            end
        end

        // Rotate so that the pointer position sits at bit 0.
        for (int unsigned i = 0; i < MAXN; i++) begin
            if (i < n) begin
                rot[i] = dbl[i + p];
            end
        end

        for (int unsigned i = 0; i < MAXN; i++) begin
            if (i < n && !found && rot[i]) begin
                grot[i] = 1'b1;
                found   = 1'b1;
            end
        end

        for (int unsigned i = 0; i < MAXN; i++) begin
            if (i < n) begin
                g[(i + p) % n] = grot[i];
            end
        end

        return g;
    endfunction

endpackage

// File: rtl/umi_rr_pick.sv
// Combinational round-robin selector: one-hot grant, its encoded index and an
// any-winner flag for a given request vector and priority pointer.
module umi_rr_pick
    import umi_arb_pkg::*;
#(
    parameter int unsigned N  = 5,
    parameter int unsigned IW = clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] gidx,
    output logic          any
);

    logic [MAXN-1:0] valid_ext;
    logic [MAXN-1:0] grant_full;

    always_comb begin
        valid_ext          = '0;
        valid_ext[N-1:0]   = valid;
        grant_full         = rr_pick(valid_ext, N, 32'(ptr));
        grant              = grant_full[N-1:0];
        any                = |grant_full;
    end

    always_comb begin
        gidx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) begin
                gidx = gidx | IW'(i);
            end
        end
    end

endmodule

// File: rtl/umi_req_rr_arbiter.sv
// N-to-1 round-robin merge of UMI request channels into one registered
// downstream request port, exporting the winning port index.
module umi_req_rr_arbiter
    import umi_arb_pkg::*;
#(
    parameter int unsigned N  = 5,
    parameter int unsigned CW = 32,
    parameter int unsigned AW = 64,
    parameter int unsigned DW = 256,
    localparam int unsigned IW = clog2(N)
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [N-1:0]    uhost_valid,
    input  logic [N*CW-1:0] uhost_cmd,
    input  logic [N*AW-1:0] uhost_dstaddr,
    input  logic [N*AW-1:0] uhost_srcaddr,
    input  logic [N*DW-1:0] uhost_data,
    output logic [N-1:0]    uhost_ready,
    output logic            udev_valid,
    output logic [CW-1:0]   udev_cmd,
    output logic [AW-1:0]   udev_dstaddr,
    output logic [AW-1:0]   udev_srcaddr,
    output logic [DW-1:0]   udev_data,
    output logic [IW-1:0]   udev_src,
    input  logic            udev_ready
);

    logic [N-1:0]  grant;
    logic [IW-1:0] gidx;
    logic          any;
    logic          load;

    logic          valid_q;
    logic [CW-1:0] cmd_q,  cmd_d;
    logic [AW-1:0] dst_q,  dst_d;
    logic [AW-1:0] srca_q, srca_d;
    logic [DW-1:0] data_q, data_d;
    logic [IW-1:0] src_q;
    logic [IW-1:0] ptr_q,  ptr_d;

    umi_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .valid (uhost_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .gidx  (gidx),
        .any   (any)
    );

    assign load = ~valid_q | udev_ready;

    // Gated by nreset so no host sees ready while the stage is held in reset.
    assign uhost_ready = (load & nreset) ? grant : '0;

    // AND-OR mux keyed by the one-hot grant keeps X off unselected ports.
    always_comb begin
        cmd_d  = '0;
        dst_d  = '0;
        srca_d = '0;
        data_d = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cmd_d  = cmd_d  | (uhost_cmd[i*CW +: CW]     & {CW{grant[i]}});
            dst_d  = dst_d  | (uhost_dstaddr[i*AW +: AW] & {AW{grant[i]}});
            srca_d = srca_d | (uhost_srcaddr[i*AW +: AW] & {AW{grant[i]}});
            data_d = data_d | (uhost_data[i*DW +: DW]    & {DW{grant[i]}});
        end
    end

    always_comb begin
        if (gidx == IW'(N - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = gidx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            valid_q <= 1'b0;
            cmd_q   <= '0;
            dst_q   <= '0;
            srca_q  <= '0;
            data_q  <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
        end else if (load) begin
            valid_q <= any;
            if (any) begin
                cmd_q  <= cmd_d;
                dst_q  <= dst_d;
                srca_q <= srca_d;
                data_q <= data_d;
                src_q  <= gidx;
                ptr_q  <= ptr_d;
            end
        end
    end

    assign udev_valid   = valid_q;
    assign udev_cmd     = cmd_q;
    assign udev_dstaddr = dst_q;
    assign udev_srcaddr = srca_q;
    assign udev_data    = data_q;
    assign udev_src     = src_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!nreset)
        $onehot0(uhost_ready));

    a_stall_hold: assert property (@(posedge clk) disable iff (!nreset)
        (valid_q & ~udev_ready) |=> (valid_q && $stable(src_q) && $stable(cmd_q)
                                     && $stable(data_q)));

endmodule

// File: tb/tb_umi_req_rr_arbiter.sv
// Self-checking bench for umi_req_rr_arbiter: directed vector table, async
// reset corner case and a randomized run against a beat-level reference model.
module tb_umi_req_rr_arbiter;

    localparam int N  = 5;
    localparam int CW = 32;
    localparam int AW = 64;
    localparam int DW = 256;
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            nreset;
    logic [N-1:0]    uhost_valid;
    logic [N*CW-1:0] uhost_cmd;
    logic [N*AW-1:0] uhost_dstaddr;
    logic [N*AW-1:0] uhost_srcaddr;
    logic [N*DW-1:0] uhost_data;
    logic [N-1:0]    uhost_ready;
    logic            udev_valid;
    logic [CW-1:0]   udev_cmd;
    logic [AW-1:0]   udev_dstaddr;
    logic [AW-1:0]   udev_srcaddr;
    logic [DW-1:0]   udev_data;
    logic [IW-1:0]   udev_src;
    logic            udev_ready;

    always #5 clk = ~clk;

    umi_req_rr_arbiter #(
        .N  (N),
        .CW (CW),
        .AW (AW),
        .DW (DW)
    ) dut (
        .clk           (clk),
        .nreset        (nreset),
        .uhost_valid   (uhost_valid),
        .uhost_cmd     (uhost_cmd),
        .uhost_dstaddr (uhost_dstaddr),
        .uhost_srcaddr (uhost_srcaddr),
        .uhost_data    (uhost_data),
        .uhost_ready   (uhost_ready),
        .udev_valid    (udev_valid),
        .udev_cmd      (udev_cmd),
        .udev_dstaddr  (udev_dstaddr),
        .udev_srcaddr  (udev_srcaddr),
        .udev_data     (udev_data),
        .udev_src      (udev_src),
        .udev_ready    (udev_ready)
    );

    // Reference model: the beat held downstream, the rotating priority start
    // and a per-port sequence number that tags each offered beat.
    int       checks   = 0;
    int       failures = 0;
    bit       m_valid  = 1'b0;
    int       m_port   = 0;
    int       m_seq    = 0;
    int       m_ptr    = 0;
    int       seq[N];
    int       out_cnt[N];
    int       last_acc = -1;
    logic [N-1:0] drv_valid = '0;
    logic         drv_ready = 1'b0;

    typedef struct {
        logic [N-1:0] uv;
        logic         ur;
        logic [N-1:0] exp_rdy;
        logic         exp_v;
        int           exp_src;
    } vec_t;

    vec_t tbl[21];

    function automatic logic [CW-1:0] mk_cmd(int p, int s);
        return {4'(p), 28'(s)};
    endfunction

    function automatic logic [AW-1:0] mk_dst(int p, int s);
        return {32'hD000_0000 | 32'(p), 32'(s)};
    endfunction

    function automatic logic [AW-1:0] mk_srca(int p, int s);
        return {32'(s) ^ 32'h5A5A_5A5A, 32'(p)};
    endfunction

    function automatic logic [DW-1:0] mk_data(int p, int s);
        return {32'(p), 32'(s), ~32'(s), 32'(s + p), 32'hC0DE_0000 | 32'(p),
                32'(s * 7), 32'(p * 3), 32'(s)};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        uhost_valid = drv_valid;
        udev_ready  = drv_ready;
        for (int p = 0; p < N; p++) begin
            uhost_cmd[p*CW +: CW]     = mk_cmd(p, seq[p]);
            uhost_dstaddr[p*AW +: AW] = mk_dst(p, seq[p]);
            uhost_srcaddr[p*AW +: AW] = mk_srca(p, seq[p]);
            uhost_data[p*DW +: DW]    = mk_data(p, seq[p]);
        end
    endtask

    // One clock: drive, compare at the falling edge, advance the model.
    task automatic step(output logic [N-1:0] o_rdy, output logic o_v, output int o_src);
        int           w;
        bit           load;
        logic [N-1:0] er;
        int           sp;
        drive();
        @(negedge clk);
        o_rdy = uhost_ready;
        o_v   = udev_valid;
        o_src = int'(udev_src);
        chk("udev_valid", udev_valid, m_valid);
        if (m_valid) begin
            chk("udev_src", udev_src, m_port);
            chk("udev_cmd", udev_cmd, mk_cmd(m_port, m_seq));
            chk("udev_dstaddr", udev_dstaddr, mk_dst(m_port, m_seq));
            chk("udev_srcaddr", udev_srcaddr, mk_srca(m_port, m_seq));
            chk("udev_data", udev_data, mk_data(m_port, m_seq));
        end
        load = !m_valid || drv_ready;
        w = -1;
        if (load) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && drv_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
        end
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        chk("uhost_ready", uhost_ready, er);
        if (udev_valid === 1'b1 && drv_ready) begin
            sp = int'(udev_src);
            if (sp < N) begin
                chk("order_port", udev_data[255:224], sp);
                chk("order_seq", udev_data[223:192], out_cnt[sp]);
                out_cnt[sp]++;
            end
        end
        @(posedge clk);
        #1;
        if (w >= 0) begin
            m_valid = 1'b1;
            m_port  = w;
            m_seq   = seq[w];
            seq[w]++;
            m_ptr   = (w + 1) % N;
        end else if (load) begin
            m_valid = 1'b0;
        end
        last_acc = w;
    endtask

    // Asserts reset mid-cycle; in-flight beat is discarded by the model.
    task automatic async_reset();
        #2;
        nreset = 1'b0;
        #1;
        chk("rst_async_udev_valid", udev_valid, 1'b0);
        chk("rst_async_uhost_ready", uhost_ready, '0);
        m_valid = 1'b0;
        m_ptr   = 0;
        for (int p = 0; p < N; p++) out_cnt[p] = seq[p];
        @(posedge clk);
        #1;
        chk("rst_hold_udev_valid", udev_valid, 1'b0);
        nreset = 1'b1;
    endtask

    initial begin
        logic [N-1:0] r_rdy;
        logic         r_v;
        int           r_src;
        logic [N-1:0] pend;
        int           beats;
        int           cyc;

        tbl[0]  = '{5'b11111, 1'b1, 5'b00001, 1'b0, 0};
        tbl[1]  = '{5'b11111, 1'b1, 5'b00010, 1'b1, 0};
        tbl[2]  = '{5'b11111, 1'b1, 5'b00100, 1'b1, 1};
        tbl[3]  = '{5'b11111, 1'b1, 5'b01000, 1'b1, 2};
        tbl[4]  = '{5'b11111, 1'b1, 5'b10000, 1'b1, 3};
        tbl[5]  = '{5'b11111, 1'b1, 5'b00001, 1'b1, 4};
        tbl[6]  = '{5'b11111, 1'b1, 5'b00010, 1'b1, 0};
        tbl[7]  = '{5'b11111, 1'b1, 5'b00100, 1'b1, 1};
        tbl[8]  = '{5'b11111, 1'b1, 5'b01000, 1'b1, 2};
        tbl[9]  = '{5'b11111, 1'b1, 5'b10000, 1'b1, 3};
        tbl[10] = '{5'b01000, 1'b1, 5'b01000, 1'b1, 4};
        tbl[11] = '{5'b01000, 1'b0, 5'b00000, 1'b1, 3};
        tbl[12] = '{5'b01000, 1'b0, 5'b00000, 1'b1, 3};
        tbl[13] = '{5'b01000, 1'b1, 5'b01000, 1'b1, 3};
        tbl[14] = '{5'b00000, 1'b1, 5'b00000, 1'b1, 3};
        tbl[15] = '{5'b00000, 1'b1, 5'b00000, 1'b0, 0};
        tbl[16] = '{5'b00010, 1'b1, 5'b00010, 1'b0, 0};
        tbl[17] = '{5'b10010, 1'b1, 5'b10000, 1'b1, 1};
        tbl[18] = '{5'b00010, 1'b1, 5'b00010, 1'b1, 4};
        tbl[19] = '{5'b00000, 1'b1, 5'b00000, 1'b1, 1};
        tbl[20] = '{5'b00000, 1'b1, 5'b00000, 1'b0, 0};

        for (int p = 0; p < N; p++) begin
            seq[p]     = 0;
            out_cnt[p] = 0;
        end

        nreset    = 1'b0;
        drv_valid = '1;
        drv_ready = 1'b1;
        drive();
        #3;
        chk("reset_uhost_ready", uhost_ready, '0);
        chk("reset_udev_valid", udev_valid, 1'b0);
        @(posedge clk);
        #1;
        nreset = 1'b1;

        for (int i = 0; i < 21; i++) begin
            drv_valid = tbl[i].uv;
            drv_ready = tbl[i].ur;
            step(r_rdy, r_v, r_src);
            chk($sformatf("tbl%0d_rdy", i), r_rdy, tbl[i].exp_rdy);
            chk($sformatf("tbl%0d_valid", i), r_v, tbl[i].exp_v);
            if (tbl[i].exp_v) chk($sformatf("tbl%0d_src", i), r_src, tbl[i].exp_src);
        end

        // Load a beat from port 2, stall it, then reset underneath it.
        drv_valid = 5'b00100;
        drv_ready = 1'b0;
        step(r_rdy, r_v, r_src);
        drv_valid = 5'b00000;
        step(r_rdy, r_v, r_src);
        chk("stall_before_reset_valid", r_v, 1'b1);
        drv_valid = '1;
        drive();
        async_reset();
        drv_valid = '1;
        drv_ready = 1'b1;
        step(r_rdy, r_v, r_src);
        chk("post_reset_first_grant", r_rdy, 5'b00001);
        chk("post_reset_valid", r_v, 1'b0);
        step(r_rdy, r_v, r_src);
        chk("post_reset_src", r_src, 0);
        chk("post_reset_second_grant", r_rdy, 5'b00010);

        // Randomized: each port keeps its request up until it is accepted.
        pend  = '0;
        beats = 0;
        cyc   = 0;
        while (beats < 10000 && cyc < 40000) begin
            for (int p = 0; p < N; p++) begin
                if (!pend[p]) pend[p] = (($urandom % 3) != 0);
            end
            drv_valid = pend;
            drv_ready = (($urandom % 4) != 0);
            step(r_rdy, r_v, r_src);
            if (last_acc >= 0) begin
                pend[last_acc] = 1'b0;
                beats++;
            end
            cyc++;
        end
        chk("random_beats_done", (beats >= 10000), 1'b1);

        drv_valid = '0;
        drv_ready = 1'b1;
        step(r_rdy, r_v, r_src);
        step(r_rdy, r_v, r_src);
        chk("drain_valid", r_v, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
